// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ID->EX issue stage: ALU Func codes, MIPS opcode/funct values
// and the decoded-instruction record passed from the decoder to the issue register.
package alu_issue_stage_pkg;

    localparam logic [3:0] FUNC_AND  = 4'b0000;
    localparam logic [3:0] FUNC_OR   = 4'b0001;
    localparam logic [3:0] FUNC_XOR  = 4'b0010;
    localparam logic [3:0] FUNC_XNOR = 4'b0011;
    localparam logic [3:0] FUNC_ADD  = 4'b0100;
    localparam logic [3:0] FUNC_SUB  = 4'b1100;
    localparam logic [3:0] FUNC_SLT  = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2,
        IMM_LUI  = 2'd3
    } imm_kind_e;

    typedef struct packed {
        logic [3:0] func;
        imm_kind_e  imm_kind;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       we;
        logic       mem_rd;
        logic       mem_wr;
        logic       uses_rt;
        logic       zero_in1;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and EX-side handshake/bus of the issue stage; master is the surrounding
// pipeline, slave is the issue stage itself.
interface alu_issue_stage_if #(parameter int XLEN = 32);

    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_rs_data;
    logic [XLEN-1:0] id_rt_data;

    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_in1;
    logic [XLEN-1:0] ex_in2;
    logic [3:0]      ex_func;
    logic [4:0]      ex_rd;
    logic            ex_we;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_illegal;

    modport master (
        output id_valid, id_instr, id_rs_data, id_rt_data, ex_ready,
        input  id_ready, ex_valid, ex_in1, ex_in2, ex_func, ex_rd, ex_we,
               ex_mem_rd, ex_mem_wr, ex_store_data, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, id_rs_data, id_rt_data, ex_ready,
        output id_ready, ex_valid, ex_in1, ex_in2, ex_func, ex_rd, ex_we,
               ex_mem_rd, ex_mem_wr, ex_store_data, ex_illegal
    );

endinterface

// File: rtl/alu_issue_stage_decoder.sv
// Combinational MIPS R/I decoder: instruction word -> ALU Func, immediate, destination,
// write/memory flags, rt usage and illegal-opcode indication.
module alu_func_decoder
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output decode_t         dec,
    output logic [XLEN-1:0] imm
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic signed [31:0] lui_word;

    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];
    assign lui_word = {imm16, 16'h0000};

    always_comb begin
        dec          = '0;
        dec.imm_kind = IMM_NONE;
        dec.rs       = instr[25:21];
        dec.rt       = instr[20:16];
        case (op)
            OP_RTYPE: begin
                dec.uses_rt = 1'b1;
                dec.rd      = instr[15:11];
                dec.we      = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec.func = FUNC_ADD;
                    FN_SUB, FN_SUBU: dec.func = FUNC_SUB;
                    FN_AND:          dec.func = FUNC_AND;
                    FN_OR:           dec.func = FUNC_OR;
                    FN_XOR:          dec.func = FUNC_XOR;
                    FN_SLT:          dec.func = FUNC_SLT;
                    default:         dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.func = FUNC_ADD;  dec.imm_kind = IMM_SEXT;
                dec.rd   = instr[20:16]; dec.we = 1'b1;
            end
            OP_SLTI: begin
                dec.func = FUNC_SLT;  dec.imm_kind = IMM_SEXT;
                dec.rd   = instr[20:16]; dec.we = 1'b1;
            end
            OP_ANDI: begin
                dec.func = FUNC_AND;  dec.imm_kind = IMM_ZEXT;
                dec.rd   = instr[20:16]; dec.we = 1'b1;
            end
            OP_ORI: begin
                dec.func = FUNC_OR;   dec.imm_kind = IMM_ZEXT;
                dec.rd   = instr[20:16]; dec.we = 1'b1;
            end
            OP_XORI: begin
                dec.func = FUNC_XOR;  dec.imm_kind = IMM_ZEXT;
                dec.rd   = instr[20:16]; dec.we = 1'b1;
            end
            OP_LUI: begin
                dec.func     = FUNC_ADD; dec.imm_kind = IMM_LUI;
                dec.zero_in1 = 1'b1;
                dec.rd       = instr[20:16]; dec.we = 1'b1;
            end
            OP_LW: begin
                dec.func   = FUNC_ADD;  dec.imm_kind = IMM_SEXT;
                dec.rd     = instr[20:16]; dec.we = 1'b1;
                dec.mem_rd = 1'b1;
            end
            OP_SW: begin
                dec.func    = FUNC_ADD; dec.imm_kind = IMM_SEXT;
                dec.rd      = instr[20:16];
                dec.mem_wr  = 1'b1;
                dec.uses_rt = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // Unsupported encodings still flow down the pipe, but must have no side effects.
        if (dec.illegal) begin
            dec.func     = '0;
            dec.we       = 1'b0;
            dec.mem_rd   = 1'b0;
            dec.mem_wr   = 1'b0;
            dec.rd       = '0;
            dec.imm_kind = IMM_NONE;
            dec.zero_in1 = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.we = 1'b0;
        end
    end

    always_comb begin
        imm = '0;
        case (dec.imm_kind)
            IMM_SEXT: imm = XLEN'(signed'(imm16));
            IMM_ZEXT: imm = XLEN'(imm16);
            IMM_LUI:  imm = XLEN'(lui_word);
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register for the ALU: operand forwarding, load-use bubble insertion,
// flush handling and a saturating count of inserted bubbles.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    alu_issue_stage_if.slave       bus,
    input  logic                   fwd_ex_we,
    input  logic [4:0]             fwd_ex_rd,
    input  logic [XLEN-1:0]        fwd_ex_data,
    input  logic                   fwd_mem_we,
    input  logic [4:0]             fwd_mem_rd,
    input  logic [XLEN-1:0]        fwd_mem_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    decode_t         dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] in1_next;
    logic [XLEN-1:0] in2_next;
    logic            load_use;
    logic            adv;

    alu_func_decoder #(.XLEN(XLEN)) u_decoder (
        .instr (bus.id_instr),
        .dec   (dec),
        .imm   (imm)
    );

    // The younger result (EX) wins over MEM; $0 is hardwired regardless of forwarding.
    function automatic logic [XLEN-1:0] select_operand(
        input logic [4:0]      r,
        input logic [XLEN-1:0] rf_data,
        input logic            ex_we,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data
    );
        if (r == 5'd0)                 return '0;
        else if (ex_we && ex_rd == r)  return ex_data;
        else if (mem_we && mem_rd == r) return mem_data;
        else                           return rf_data;
    endfunction

    assign rs_val = select_operand(dec.rs, bus.id_rs_data, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                   fwd_mem_we, fwd_mem_rd, fwd_mem_data);
    assign rt_val = select_operand(dec.rt, bus.id_rt_data, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                   fwd_mem_we, fwd_mem_rd, fwd_mem_data);

    assign in1_next = dec.zero_in1 ? '0 : rs_val;
    assign in2_next = (dec.imm_kind != IMM_NONE) ? imm : rt_val;

    assign load_use = bus.ex_valid && bus.ex_mem_rd && (bus.ex_rd != 5'd0) &&
                      ((bus.ex_rd == dec.rs) || (dec.uses_rt && (bus.ex_rd == dec.rt)));
    assign adv          = !bus.ex_valid || bus.ex_ready;
    assign bus.id_ready = flush || (adv && !load_use);

    // Flush beats everything; a load-use hazard turns the advance into a bubble while
    // the dependent instruction waits upstream; without advance the register holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_in1        <= '0;
            bus.ex_in2        <= '0;
            bus.ex_func       <= '0;
            bus.ex_rd         <= '0;
            bus.ex_we         <= 1'b0;
            bus.ex_mem_rd     <= 1'b0;
            bus.ex_mem_wr     <= 1'b0;
            bus.ex_store_data <= '0;
            bus.ex_illegal    <= 1'b0;
            stall_cnt         <= '0;
        end else if (flush) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_in1        <= '0;
            bus.ex_in2        <= '0;
            bus.ex_func       <= '0;
            bus.ex_rd         <= '0;
            bus.ex_we         <= 1'b0;
            bus.ex_mem_rd     <= 1'b0;
            bus.ex_mem_wr     <= 1'b0;
            bus.ex_store_data <= '0;
            bus.ex_illegal    <= 1'b0;
        end else if (adv) begin
            if (load_use) begin
                bus.ex_valid  <= 1'b0;
                bus.ex_we     <= 1'b0;
                bus.ex_mem_rd <= 1'b0;
                bus.ex_mem_wr <= 1'b0;
                if (stall_cnt != '1) begin
                    stall_cnt <= stall_cnt + STALL_CNT_W'(1);
                end
            end else if (bus.id_valid) begin
                bus.ex_valid      <= 1'b1;
                bus.ex_in1        <= in1_next;
                bus.ex_in2        <= in2_next;
                bus.ex_func       <= dec.func;
                bus.ex_rd         <= dec.rd;
                bus.ex_we         <= dec.we;
                bus.ex_mem_rd     <= dec.mem_rd;
                bus.ex_mem_wr     <= dec.mem_wr;
                bus.ex_store_data <= rt_val;
                bus.ex_illegal    <= dec.illegal;
            end else begin
                bus.ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode, forwarding, load-use bubble,
// back-pressure with flush, and immediate extension corner cases.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fwd_ex_we;
    logic [4:0]  fwd_ex_rd;
    logic [31:0] fwd_ex_data;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_data;
    logic [15:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .fwd_ex_we    (fwd_ex_we),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_mem_we   (fwd_mem_we),
        .fwd_mem_rd   (fwd_mem_rd),
        .fwd_mem_data (fwd_mem_data),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic [31:0] rs_data, input logic [31:0] rt_data);
        bus.id_valid   = valid;
        bus.id_instr   = instr;
        bus.id_rs_data = rs_data;
        bus.id_rt_data = rt_data;
        #1;
    endtask

    task automatic setForward(input logic ex_we, input logic [4:0] ex_rd, input logic [31:0] ex_data,
                              input logic mem_we, input logic [4:0] mem_rd, input logic [31:0] mem_data);
        fwd_ex_we    = ex_we;
        fwd_ex_rd    = ex_rd;
        fwd_ex_data  = ex_data;
        fwd_mem_we   = mem_we;
        fwd_mem_rd   = mem_rd;
        fwd_mem_data = mem_data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.ex_ready = 1'b1;
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // T1: reset state
        checkOutput("t1_ex_valid", 32'(bus.ex_valid), 32'h0);
        checkOutput("t1_ex_in1", bus.ex_in1, 32'h0);
        checkOutput("t1_ex_in2", bus.ex_in2, 32'h0);
        checkOutput("t1_ex_func", 32'(bus.ex_func), 32'h0);
        checkOutput("t1_ex_rd", 32'(bus.ex_rd), 32'h0);
        checkOutput("t1_ex_we", 32'(bus.ex_we), 32'h0);
        checkOutput("t1_id_ready", 32'(bus.id_ready), 32'h1);
        checkOutput("t1_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        checkOutput("t1_idle_valid", 32'(bus.ex_valid), 32'h0);

        // T2: sub $3,$1,$2
        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd3, 6'h22), 32'd10, 32'd3);
        checkOutput("t2_id_ready", 32'(bus.id_ready), 32'h1);
        tick();
        checkOutput("t2_ex_valid", 32'(bus.ex_valid), 32'h1);
        checkOutput("t2_ex_func", 32'(bus.ex_func), 32'hC);
        checkOutput("t2_ex_in1", bus.ex_in1, 32'd10);
        checkOutput("t2_ex_in2", bus.ex_in2, 32'd3);
        checkOutput("t2_ex_rd", 32'(bus.ex_rd), 32'd3);
        checkOutput("t2_ex_we", 32'(bus.ex_we), 32'h1);

        // T3: lw $5,4($1) followed by dependent add $6,$5,$5
        applyStimulus(1'b1, itype(6'h23, 5'd1, 5'd5, 16'd4), 32'h100, 32'h0);
        tick();
        checkOutput("t3_lw_mem_rd", 32'(bus.ex_mem_rd), 32'h1);
        checkOutput("t3_lw_in1", bus.ex_in1, 32'h100);
        checkOutput("t3_lw_in2", bus.ex_in2, 32'h4);
        checkOutput("t3_lw_rd", 32'(bus.ex_rd), 32'd5);
        applyStimulus(1'b1, rtype(5'd5, 5'd5, 5'd6, 6'h20), 32'h0, 32'h0);
        checkOutput("t3_stall_ready", 32'(bus.id_ready), 32'h0);
        tick();
        checkOutput("t3_bubble_valid", 32'(bus.ex_valid), 32'h0);
        checkOutput("t3_bubble_mem_rd", 32'(bus.ex_mem_rd), 32'h0);
        checkOutput("t3_stall_cnt", 32'(stall_cnt), 32'h1);
        setForward(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        #1;
        checkOutput("t3_resume_ready", 32'(bus.id_ready), 32'h1);
        tick();
        checkOutput("t3_add_valid", 32'(bus.ex_valid), 32'h1);
        checkOutput("t3_add_in1", bus.ex_in1, 32'h1234);
        checkOutput("t3_add_in2", bus.ex_in2, 32'h1234);
        checkOutput("t3_add_rd", 32'(bus.ex_rd), 32'd6);
        checkOutput("t3_stall_hold", 32'(stall_cnt), 32'h1);

        // T4: EX forward beats MEM; $0 never forwarded
        setForward(1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB);
        applyStimulus(1'b1, rtype(5'd7, 5'd0, 5'd8, 6'h20), 32'h55, 32'h66);
        tick();
        checkOutput("t4_ex_priority", bus.ex_in1, 32'hAA);
        checkOutput("t4_rt_zero", bus.ex_in2, 32'h0);
        setForward(1'b1, 5'd0, 32'hCC, 1'b1, 5'd0, 32'hDD);
        applyStimulus(1'b1, rtype(5'd0, 5'd0, 5'd9, 6'h25), 32'h77, 32'h77);
        tick();
        checkOutput("t4_rs_zero", bus.ex_in1, 32'h0);
        checkOutput("t4_or_func", 32'(bus.ex_func), 32'h1);

        // T5: back-pressure for three cycles with a flush in the second
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd10, 6'h26), 32'h0F, 32'hF0);
        tick();
        checkOutput("t5_xor_func", 32'(bus.ex_func), 32'h2);
        checkOutput("t5_xor_in2", bus.ex_in2, 32'hF0);
        bus.ex_ready = 1'b0;
        applyStimulus(1'b1, rtype(5'd3, 5'd4, 5'd11, 6'h24), 32'h1, 32'h2);
        checkOutput("t5_blocked_ready", 32'(bus.id_ready), 32'h0);
        tick();
        checkOutput("t5_hold1_valid", 32'(bus.ex_valid), 32'h1);
        checkOutput("t5_hold1_in1", bus.ex_in1, 32'h0F);
        checkOutput("t5_hold1_rd", 32'(bus.ex_rd), 32'd10);
        flush = 1'b1;
        #1;
        checkOutput("t5_flush_ready", 32'(bus.id_ready), 32'h1);
        tick();
        flush = 1'b0;
        checkOutput("t5_flush_valid", 32'(bus.ex_valid), 32'h0);
        checkOutput("t5_flush_in1", bus.ex_in1, 32'h0);
        checkOutput("t5_flush_func", 32'(bus.ex_func), 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        checkOutput("t5_empty_ready", 32'(bus.id_ready), 32'h1);
        tick();
        checkOutput("t5_empty_valid", 32'(bus.ex_valid), 32'h0);
        bus.ex_ready = 1'b1;

        // T6: immediate extension, illegal opcode, lui, sw, write to $0
        applyStimulus(1'b1, itype(6'h0C, 5'd0, 5'd12, 16'hFFFF), 32'h5, 32'h0);
        tick();
        checkOutput("t6_andi_in2", bus.ex_in2, 32'h0000FFFF);
        checkOutput("t6_andi_func", 32'(bus.ex_func), 32'h0);
        applyStimulus(1'b1, itype(6'h0A, 5'd0, 5'd13, 16'hFFFF), 32'h0, 32'h0);
        tick();
        checkOutput("t6_slti_in2", bus.ex_in2, 32'hFFFFFFFF);
        checkOutput("t6_slti_func", 32'(bus.ex_func), 32'hD);
        applyStimulus(1'b1, itype(6'h3F, 5'd1, 5'd14, 16'h0), 32'h0, 32'h0);
        tick();
        checkOutput("t6_illegal", 32'(bus.ex_illegal), 32'h1);
        checkOutput("t6_illegal_valid", 32'(bus.ex_valid), 32'h1);
        checkOutput("t6_illegal_func", 32'(bus.ex_func), 32'h0);
        checkOutput("t6_illegal_we", 32'(bus.ex_we), 32'h0);
        applyStimulus(1'b1, itype(6'h0F, 5'd3, 5'd14, 16'h1234), 32'h999, 32'h0);
        tick();
        checkOutput("t6_lui_in1", bus.ex_in1, 32'h0);
        checkOutput("t6_lui_in2", bus.ex_in2, 32'h12340000);
        checkOutput("t6_lui_illegal", 32'(bus.ex_illegal), 32'h0);
        applyStimulus(1'b1, itype(6'h2B, 5'd1, 5'd2, 16'd8), 32'h200, 32'h99);
        tick();
        checkOutput("t6_sw_mem_wr", 32'(bus.ex_mem_wr), 32'h1);
        checkOutput("t6_sw_we", 32'(bus.ex_we), 32'h0);
        checkOutput("t6_sw_store", bus.ex_store_data, 32'h99);
        checkOutput("t6_sw_in2", bus.ex_in2, 32'h8);
        applyStimulus(1'b1, rtype(5'd1, 5'd2, 5'd0, 6'h20), 32'h1, 32'h2);
        tick();
        checkOutput("t6_r0_we", 32'(bus.ex_we), 32'h0);
        checkOutput("t6_stall_final", 32'(stall_cnt), 32'h1);

        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
